mem_ctrl_arb: RTL
=================

Name: mem_ctrl_arb

Overview:
- Parametrised successor to the single-port byte-serial memory controller.
- Arbitrates two requesters, a data port (load/store) and an instruction-fetch port, onto one byte-wide RAM/IO bus.
- Supports byte, half and word accesses, sign or zero extension on loads, configurable RAM read latency, and round-robin fairness between ports.
- Sits between the IF/MEM pipeline stages and the external RAM bus.

Parameters:
- ADDR_WIDTH, 32: width of all address buses.
- DATA_BYTES, 4: bytes per word; legal range 2..8. Data buses are 8*DATA_BYTES bits wide.
- RD_LAT, 1: cycles from mem_a driven until the matching byte appears on mem_din; legal range 1..3.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- d_req  in  1  data-port request; held until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_size  in  2  0 = byte, 1 = half, 2 or 3 = word (DATA_BYTES bytes).
- d_signed  in  1  load sign-extends when 1, zero-extends when 0.
- d_addr  in  ADDR_WIDTH  data byte address.
- d_wdata  in  8*DATA_BYTES  store data; low bytes are used first.
- d_rdata  out  8*DATA_BYTES  load result.
- d_done  out  1  one-cycle completion pulse for the data port.
- i_req  in  1  fetch request; held until i_done.
- i_addr  in  ADDR_WIDTH  fetch byte address.
- i_inst  out  8*DATA_BYTES  fetched word.
- i_done  out  1  one-cycle completion pulse for the fetch port.
- mem_din  in  8  RAM read byte.
- mem_dout  out  8  RAM write byte.
- mem_a  out  ADDR_WIDTH  RAM byte address.
- mem_wr  out  1  1 = write strobe, 0 = read.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - All outputs go to 0 and state goes to IDLE.
  - last_grant resets to INST, so data wins the first tie.
  - An in-flight transfer is abandoned with no done pulse; partially written bytes stay in RAM.
- States: IDLE, WRITE, READ, FETCH.
- IDLE:
  - mem_wr = 0.
  - Requests are sampled only in IDLE.
  - If exactly one port requests, grant it.
  - If both request, grant the port not equal to last_grant, then update last_grant.
  - On grant, latch address, size, signed flag and write data internally. Later changes to request inputs are ignored until done.
- Byte count N:
  - d_size 0 gives N=1, 1 gives N=2, 2 or 3 gives N=DATA_BYTES.
  - Fetch always uses N=DATA_BYTES.
- Addressing: byte k uses address base+k, wrapping modulo 2^ADDR_WIDTH. No alignment check.
- WRITE:
  - In the cycle after the grant edge, drive mem_a=base, mem_dout=byte0, mem_wr=1.
  - Each following cycle issues the next byte.
  - After byte N-1 has been driven for one cycle: mem_wr returns to 0, d_done pulses, state returns to IDLE.
  - Grant-to-d_done latency is N+1 cycles.
- READ / FETCH:
  - Issue addresses base..base+N-1 on consecutive cycles with mem_wr=0.
  - Capture byte k from mem_din RD_LAT cycles after its address was driven.
  - The done pulse comes in the cycle after the last capture, so latency is N+RD_LAT+1 cycles.
- Load result:
  - d_rdata = assembled bytes, little-endian.
  - Bits above 8N are filled with the top captured bit when d_signed=1, else 0.
- Fetch result: i_inst receives all DATA_BYTES bytes; d_signed is ignored.
- Output hold:
  - d_rdata and i_inst update only at their own completion and hold otherwise.
  - A store never changes d_rdata.
- Done pulses:
  - d_done and i_done are each exactly one cycle, registered, and never both high together.
  - The controller is back in IDLE on the done cycle and may accept a new request that same edge (back-to-back).
  - A requester that keeps its req high after done is treated as issuing a new request.
- mem_wr is never 1 outside WRITE.

Test Plan:
- Reset mid-read: assert rst two cycles into a word load. All outputs are 0 immediately, no d_done, and the next request completes normally.
- Word store (DATA_BYTES=4, RD_LAT=1): d_addr=0x100, d_wdata=0xAABBCCDD. RAM[0x100..0x103] = DD,CC,BB,AA, mem_wr high exactly 4 cycles, d_done 5 cycles after grant.
- Signed byte load: RAM[0x200]=0x80, d_size=0, d_signed=1 gives d_rdata=0xFFFFFF80. Repeat with d_signed=0 to get 0x00000080. Half load of 0x8001 with signed=1 gives 0xFFFF8001.
- Fetch latency sweep: i_addr=0x0 holding 0x00000013. i_inst=0x00000013, i_done at grant+6 for RD_LAT=1 and grant+8 for RD_LAT=3.
- Contention: d_req and i_req held continuously from reset. Grants go D,I,D,I, done pulses never overlap, and each port completes within two transfers.
- Wrap-around: word load at d_addr=0xFFFFFFFE reads bytes 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1 in order.

Source files
------------

// File: rtl/mem_ctrl_arb.sv
// rtl/mem_ctrl_arb.sv - two-port round-robin byte-serial memory controller
// Data (load/store) and fetch ports share one byte-wide RAM bus; reads are pipelined by RD_LAT.
module mem_ctrl_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_BYTES = 4,
  parameter int RD_LAT     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [1:0]              d_size,
  input  logic                    d_signed,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [8*DATA_BYTES-1:0] d_wdata,
  output logic [8*DATA_BYTES-1:0] d_rdata,
  output logic                    d_done,
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic [8*DATA_BYTES-1:0] i_inst,
  output logic                    i_done,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [ADDR_WIDTH-1:0]   mem_a,
  output logic                    mem_wr,
  output logic                    busy
);

  localparam int DW = 8 * DATA_BYTES;
  localparam int CW = 4;
  localparam logic [CW-1:0] RL = CW'(RD_LAT);
  localparam logic [CW-1:0] NW = CW'(DATA_BYTES);
  localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, FETCH} state_t;

  state_t          state;
  logic            last_inst;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   n_bytes;
  logic            sgn;
  logic [DW-1:0]   wbuf;
  logic [DW-1:0]   rbuf;

  logic            pick_d;
  logic [CW-1:0]   d_n;
  logic [CW-1:0]   cap_idx;
  logic [CW-1:0]   last_idx;
  logic [DW-1:0]   rd_word;
  logic [DW-1:0]   rd_ext;

  // The final byte is merged straight from mem_din so the result is ready on the done edge.
  always_comb begin
    pick_d = d_req && (!i_req || last_inst);
    case (d_size)
      2'd0:    d_n = CW'(1);
      2'd1:    d_n = CW'(2);
      default: d_n = NW;
    endcase
    cap_idx  = cnt - RL;
    last_idx = n_bytes - CW'(1);
    rd_word  = rbuf;
    rd_word[8*last_idx +: 8] = mem_din;
    rd_ext = rd_word;
    for (int b = 0; b < DATA_BYTES; b++) begin
      if (CW'(b) >= n_bytes && sgn && mem_din[7]) rd_ext[8*b +: 8] = 8'hFF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last_inst <= 1'b1;
      cnt       <= '0;
      n_bytes   <= '0;
      sgn       <= 1'b0;
      wbuf      <= '0;
      rbuf      <= '0;
      d_rdata   <= '0;
      i_inst    <= '0;
      d_done    <= 1'b0;
      i_done    <= 1'b0;
      mem_dout  <= '0;
      mem_a     <= '0;
      mem_wr    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      d_done <= 1'b0;
      i_done <= 1'b0;
      case (state)
        IDLE: begin
          cnt  <= '0;
          rbuf <= '0;
          if (pick_d) begin
            last_inst <= 1'b0;
            busy      <= 1'b1;
            mem_a     <= d_addr;
            n_bytes   <= d_n;
            sgn       <= d_signed;
            if (d_we) begin
              state    <= WRITE;
              mem_wr   <= 1'b1;
              mem_dout <= d_wdata[7:0];
              wbuf     <= d_wdata >> 8;
            end else begin
              state <= READ;
            end
          end else if (i_req) begin
            last_inst <= 1'b1;
            busy      <= 1'b1;
            mem_a     <= i_addr;
            n_bytes   <= NW;
            sgn       <= 1'b0;
            state     <= FETCH;
          end
        end
        WRITE: begin
          if (cnt == last_idx) begin
            mem_wr <= 1'b0;
            d_done <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt      <= cnt + CW'(1);
            mem_a    <= mem_a + A_ONE;
            mem_dout <= wbuf[7:0];
            wbuf     <= wbuf >> 8;
          end
        end
        default: begin
          // cnt counts cycles since the first address; byte j lands RL cycles after address j.
          if (cnt < last_idx) mem_a <= mem_a + A_ONE;
          if (cnt >= RL) rbuf[8*cap_idx +: 8] <= mem_din;
          if (cnt == last_idx + RL) begin
            busy  <= 1'b0;
            state <= IDLE;
            if (state == READ) begin
              d_done  <= 1'b1;
              d_rdata <= rd_ext;
            end else begin
              i_done <= 1'b1;
              i_inst <= rd_word;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule
